// File: rtl/rr_mux3_sequencer_if.sv
// Request/data bundle from three producers plus the captured
// output stream with its valid/ready handshake.
interface rr_mux3_sequencer_if #(
   parameter int WIDTH = 8
);
   logic [2:0]       req;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [2:0]       grant;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output req, d0, d1, d2, out_ready,
      input  grant, sel, out, out_valid
   );

   modport slave (
      input  req, d0, d1, d2, out_ready,
      output grant, sel, out, out_valid
   );
endinterface

// File: rtl/rr_mux3_sequencer.sv
// Round-robin 3-channel arbiter driving the 3:1 mux select,
// with a one-entry output buffer toward the consumer.
module rr_mux3_sequencer #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   rr_mux3_sequencer_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic [2:0] rot;
   logic [1:0] k;
   logic [2:0] sum;
   logic [2:0] wrap;
   logic [1:0] win;
   logic       cap;

   // rot[k] is the request of channel (ptr + k) mod 3
   always_comb begin
      rot = bus.req;
      case (ptr_q)
         2'd1:    rot = {bus.req[0], bus.req[2], bus.req[1]};
         2'd2:    rot = {bus.req[1], bus.req[0], bus.req[2]};
         default: rot = bus.req;
      endcase
      if (rot[0])      k = 2'd0;
      else if (rot[1]) k = 2'd1;
      else             k = 2'd2;
      sum  = {1'b0, ptr_q} + {1'b0, k};
      wrap = (sum >= 3'd3) ? sum - 3'd3 : sum;
      win  = wrap[1:0];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      out_d   = out_q;
      cap     = rst_n && (|bus.req) &&
                (state_q == IDLE || bus.out_ready);
      bus.grant = cap ? (3'b001 << win) : 3'b000;
      if (cap) begin
         case (win)
            2'd0:    out_d = bus.d0;
            2'd1:    out_d = bus.d1;
            default: out_d = bus.d2;
         endcase
         sel_d   = win;
         ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
         state_d = BUSY;
      end else if (state_q == BUSY && bus.out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
      end
   end

   assign bus.out_valid = (state_q == BUSY);
   assign bus.sel       = sel_q;
   assign bus.out       = out_q;
endmodule

// File: tb/tb_rr_mux3_sequencer.sv
// Directed bench: reset, round-robin, backpressure, drain,
// withdrawal/wrap and asynchronous reset mid-transfer.
module tb_rr_mux3_sequencer;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   rr_mux3_sequencer_if #(.WIDTH(8)) bus ();

   rr_mux3_sequencer #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag,
                          input logic v,
                          input logic [7:0] o,
                          input logic [1:0] s);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, "_out"},   32'(bus.out),       32'(o));
      chk({tag, "_sel"},   32'(bus.sel),       32'(s));
   endtask

   // Structural invariants sampled every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         n_chk++;
         assert (bus.sel !== 2'b11 && $onehot0(bus.grant)) else begin
            n_fail++;
            $error("FAIL invariant: sel %0b grant %0b",
                   bus.sel, bus.grant);
         end
      end
   end

   initial begin
      n_chk         = 0;
      n_fail        = 0;
      rst_n         = 1'b1;
      bus.req       = 3'b000;
      bus.d0        = 8'h00;
      bus.d1        = 8'h00;
      bus.d2        = 8'h00;
      bus.out_ready = 1'b0;
      #2;
      rst_n   = 1'b0;
      bus.req = 3'b111;
      #1;
      chk_out("rst", 1'b0, 8'h00, 2'd0);
      chk("rst_grant", 32'(bus.grant), 32'h0);
      tick;
      tick;

      // Round-robin from ptr 0
      rst_n         = 1'b1;
      bus.d0        = 8'h11;
      bus.d1        = 8'h22;
      bus.d2        = 8'h33;
      bus.out_ready = 1'b1;
      #1;
      chk("rr_g0", 32'(bus.grant), 32'b001);
      tick;
      chk_out("rr0", 1'b1, 8'h11, 2'd0);
      chk("rr_g1", 32'(bus.grant), 32'b010);
      tick;
      chk_out("rr1", 1'b1, 8'h22, 2'd1);
      chk("rr_g2", 32'(bus.grant), 32'b100);
      tick;
      chk_out("rr2", 1'b1, 8'h33, 2'd2);
      chk("rr_g3", 32'(bus.grant), 32'b001);
      tick;
      chk_out("rr3", 1'b1, 8'h11, 2'd0);

      // Drain to idle, ptr now 1
      bus.req = 3'b000;
      #1;
      chk("drain_g", 32'(bus.grant), 32'h0);
      tick;
      chk_out("drain", 1'b0, 8'h11, 2'd0);
      chk("drain_g2", 32'(bus.grant), 32'h0);

      // Single channel 1
      bus.req = 3'b010;
      bus.d1  = 8'h3C;
      #1;
      chk("single_g", 32'(bus.grant), 32'b010);
      tick;
      chk_out("single", 1'b1, 8'h3C, 2'd1);

      // Backpressure, ptr 2
      bus.req       = 3'b101;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_g", 32'(bus.grant), 32'h0);
         tick;
         chk_out("bp", 1'b1, 8'h3C, 2'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_rel_g", 32'(bus.grant), 32'b100);
      tick;
      chk_out("bp_rel", 1'b1, 8'h33, 2'd2);
      bus.req = 3'b001;
      #1;
      chk("bp_next_g", 32'(bus.grant), 32'b001);
      tick;
      chk_out("bp_next", 1'b1, 8'h11, 2'd0);
      bus.req = 3'b000;
      tick;
      chk_out("bp_idle", 1'b0, 8'h11, 2'd0);

      // Withdrawal and wrap: reach ptr 2 via channel 1
      bus.req = 3'b010;
      bus.d1  = 8'h5A;
      #1;
      chk("wd_g0", 32'(bus.grant), 32'b010);
      tick;
      chk_out("wd0", 1'b1, 8'h5A, 2'd1);
      bus.req       = 3'b100;
      bus.out_ready = 1'b0;
      #1;
      chk("wd_g1", 32'(bus.grant), 32'h0);
      tick;
      bus.req = 3'b000;
      tick;
      chk_out("wd1", 1'b1, 8'h5A, 2'd1);
      bus.req       = 3'b001;
      bus.out_ready = 1'b1;
      #1;
      chk("wrap_g", 32'(bus.grant), 32'b001);
      tick;
      chk_out("wrap", 1'b1, 8'h11, 2'd0);
      bus.req = 3'b110;
      bus.d1  = 8'hA5;
      #1;
      chk("ptr1_g", 32'(bus.grant), 32'b010);
      tick;
      chk_out("a5", 1'b1, 8'hA5, 2'd1);

      // Asynchronous reset while holding A5
      bus.req       = 3'b000;
      bus.out_ready = 1'b0;
      #1;
      rst_n   = 1'b0;
      bus.req = 3'b111;
      #1;
      chk_out("arst", 1'b0, 8'h00, 2'd0);
      chk("arst_g", 32'(bus.grant), 32'h0);
      #2;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("post_rst_g", 32'(bus.grant), 32'b001);
      tick;
      chk_out("post_rst", 1'b1, 8'h11, 2'd0);
      bus.req = 3'b000;
      tick;
      chk_out("end", 1'b0, 8'h11, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
